la_capture_array: RTL and testbench

- Parametrised, multi-channel successor to the single-bit logic-analyser delay + q/qb flop.
- Samples WIDTH logic-analyser input bits through a DEPTH-stage delay line, then registers them into true/complement outputs.
- Adds per-channel rise/fall pulses, sticky edge flags and a saturating edge counter.
- Sits between the LA input bus and the LA output bus of the user project; all outputs are fully driven (no tri-state).

---
 rtl/la_capture_array.sv | 151 +++++++++++++++
 tb/tb_la_capture_array.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/la_capture_array.sv
// la_capture_array
//   Multi-channel logic-analyser capture block. Each channel runs through a
//   DEPTH-stage delay line and is then registered into a true/complement
//   output pair. The block also reports per-channel rise/fall pulses and
//   sticky edge flags, and keeps a saturating count of edges summed over
//   all channels.
//
//   Ports
//     wb_clk_i    clock, rising edge
//     wb_rst_i    synchronous active-high reset
//     la_data_in  [WIDTH]  channel inputs
//     en          1 = advance, 0 = freeze everything
//     hold        freeze q/qb while the delay line keeps shifting
//     edge_clr    clear sticky flags and edge counter
//     q, qb       [WIDTH]  registered delayed data and its complement
//     rise, fall  [WIDTH]  one-cycle edge pulses aligned with the new q
//     sticky      [WIDTH]  any-edge-since-clear flags
//     edge_cnt    [CNT_W]  saturating edge count
//     cnt_sat     edge_cnt is at its maximum value

// Per-channel slice: delay line, output flop pair, edge pulses, sticky flag.
module la_capture_lane #(
    parameter int DEPTH = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic din_i,
    input  logic en_i,
    input  logic load_i,   // en & ~hold, shared by all lanes
    input  logic clr_i,
    output logic q_o,
    output logic qb_o,
    output logic rise_o,
    output logic fall_o,
    output logic sticky_o,
    output logic edge_o    // unregistered edge of this cycle, for the counter
);

    logic [DEPTH-1:0] stage_q, stage_d;
    logic             q_q, qb_q, rise_q, fall_q, sticky_q;
    logic             tail, rise_d, fall_d;

    always_comb begin
        stage_d    = stage_q;
        stage_d[0] = din_i;
        for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
    end

    assign tail   = stage_q[DEPTH-1];
    // Edges compare the value about to be loaded against the current q, so
    // a hold release reports at most one edge no matter what was skipped.
    assign rise_d = load_i &  tail & ~q_q;
    assign fall_d = load_i & ~tail &  q_q;
    assign edge_o = rise_d | fall_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stage_q  <= '0;
            q_q      <= 1'b0;
            qb_q     <= 1'b1;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            sticky_q <= 1'b0;
        end else if (en_i) begin
            stage_q  <= stage_d;
            if (load_i) begin
                q_q  <= tail;
                qb_q <= ~tail;
            end
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            // A clear and a new edge together leave the flag set.
            sticky_q <= (sticky_q & ~clr_i) | edge_o;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end
    end

    assign q_o      = q_q;
    assign qb_o     = qb_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;
    assign sticky_o = sticky_q;

endmodule

module la_capture_array #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic [WIDTH-1:0] la_data_in,
    input  logic             en,
    input  logic             hold,
    input  logic             edge_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] sticky,
    output logic [CNT_W-1:0] edge_cnt,
    output logic             cnt_sat
);

    logic             load;
    logic [WIDTH-1:0] edge_vec;
    logic [CNT_W:0]   n_edges, base, sum;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign load = en & ~hold;

    for (genvar g = 0; g < WIDTH; g++) begin : g_lane
        la_capture_lane #(.DEPTH(DEPTH)) u_lane (
            .clk_i    (wb_clk_i),
            .rst_i    (wb_rst_i),
            .din_i    (la_data_in[g]),
            .en_i     (en),
            .load_i   (load),
            .clr_i    (edge_clr),
            .q_o      (q[g]),
            .qb_o     (qb[g]),
            .rise_o   (rise[g]),
            .fall_o   (fall[g]),
            .sticky_o (sticky[g]),
            .edge_o   (edge_vec[g])
        );
    end

    // Sum is one bit wider than the counter; its top bit flags overflow,
    // which clamps to all ones instead of wrapping.
    always_comb begin
        n_edges = '0;
        for (int i = 0; i < WIDTH; i++)
            n_edges = n_edges + {{CNT_W{1'b0}}, edge_vec[i]};
        base  = edge_clr ? '0 : {1'b0, cnt_q};
        sum   = base + n_edges;
        cnt_d = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)  cnt_q <= '0;
        else if (en)   cnt_q <= cnt_d;
    end

    assign edge_cnt = cnt_q;
    assign cnt_sat  = &cnt_q;

endmodule

// File: tb/tb_la_capture_array.sv
module tb_la_capture_array;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] din = 2'b00;
    logic       en = 1'b1, hold = 1'b0, clr = 1'b0;
    logic [1:0] q, qb, rise, fall, sticky;
    logic [3:0] cnt;
    logic       sat;

    int pass_cnt = 0;
    int total    = 0;

    typedef struct packed {
        logic [1:0] q, qb, rise, fall, sticky;
        logic [3:0] cnt;
        logic       sat;
    } obs_t;

    obs_t exp_q[$];

    // Reference state, written from the behavioural description.
    logic [1:0] m_s0 = 0, m_s1 = 0, m_q = 0, m_rise = 0, m_fall = 0, m_sticky = 0;
    int         m_cnt = 0;

    always #5 clk = ~clk;

    la_capture_array #(.WIDTH(2), .DEPTH(2), .CNT_W(4)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .la_data_in(din),
        .en        (en),
        .hold      (hold),
        .edge_clr  (clr),
        .q         (q),
        .qb        (qb),
        .rise      (rise),
        .fall      (fall),
        .sticky    (sticky),
        .edge_cnt  (cnt),
        .cnt_sat   (sat)
    );

    // One clock: drive inputs, predict next outputs into the scoreboard,
    // clock, then pop and compare against what the DUT shows.
    task automatic step(input logic [1:0] d, input logic e, input logic h,
                        input logic c, input logic r);
        logic [1:0] rn, fn;
        int         s;
        obs_t       ex, got;
        @(negedge clk);
        din = d; en = e; hold = h; clr = c; rst = r;
        if (r) begin
            m_s0 = 0; m_s1 = 0; m_q = 0; m_rise = 0; m_fall = 0; m_sticky = 0; m_cnt = 0;
        end else if (e) begin
            rn = h ? 2'b00 : (m_s1 & ~m_q);
            fn = h ? 2'b00 : (~m_s1 & m_q);
            s = (c ? 0 : m_cnt) + $countones(rn | fn);
            m_cnt = (s > 15) ? 15 : s;
            m_sticky = (c ? 2'b00 : m_sticky) | rn | fn;
            if (!h) m_q = m_s1;
            m_rise = rn; m_fall = fn;
            m_s1 = m_s0; m_s0 = d;
        end else begin
            m_rise = 0; m_fall = 0;
        end
        exp_q.push_back({m_q, ~m_q, m_rise, m_fall, m_sticky, m_cnt[3:0], (m_cnt == 15)});
        @(posedge clk); #1;
        got = {q, qb, rise, fall, sticky, cnt, sat};
        total++;
        if (exp_q.size() == 0) begin
            $display("FAIL scoreboard: queue empty, got %h", got);
        end else begin
            ex = exp_q.pop_front();
            if (got !== ex)
                $display("FAIL scoreboard t=%0t: got q=%b qb=%b r=%b f=%b st=%b cnt=%0d sat=%b, want q=%b qb=%b r=%b f=%b st=%b cnt=%0d sat=%b",
                         $time, got.q, got.qb, got.rise, got.fall, got.sticky, got.cnt, got.sat,
                         ex.q, ex.qb, ex.rise, ex.fall, ex.sticky, ex.cnt, ex.sat);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset;
        for (int i = 0; i < 3; i++) begin
            step(2'b11, 1, 0, 0, 1);
            total++;
            if ({q, qb, rise, fall, sticky, cnt, sat} !== {2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 4'd0, 1'b0})
                $display("FAIL reset_state: q=%b qb=%b r=%b f=%b st=%b cnt=%0d sat=%b", q, qb, rise, fall, sticky, cnt, sat);
            else pass_cnt++;
        end
        step(2'b11, 1, 0, 0, 0);
        step(2'b11, 1, 0, 0, 0);
        total++;
        if (q !== 2'b00) $display("FAIL reset_latency_early: q=%b want 00", q); else pass_cnt++;
        step(2'b11, 1, 0, 0, 0);
        total++;
        if (q !== 2'b11 || rise !== 2'b11) $display("FAIL reset_release: q=%b rise=%b want 11/11", q, rise);
        else pass_cnt++;
        step(2'b11, 1, 0, 0, 0);
        total++;
        if (rise !== 2'b00) $display("FAIL reset_rise_once: rise=%b want 00", rise); else pass_cnt++;
    endtask

    task automatic test_latency;
        step(2'b00, 1, 0, 0, 1);
        step(2'b00, 1, 0, 0, 0);
        step(2'b01, 1, 0, 0, 0);
        step(2'b00, 1, 0, 0, 0);
        total++;
        if (q[0] !== 1'b0) $display("FAIL latency_early: q0=%b want 0", q[0]); else pass_cnt++;
        step(2'b00, 1, 0, 0, 0);
        total++;
        if (q[0] !== 1'b1 || rise !== 2'b01) $display("FAIL latency_rise: q0=%b rise=%b want 1/01", q[0], rise);
        else pass_cnt++;
        step(2'b00, 1, 0, 0, 0);
        total++;
        if (q[0] !== 1'b0 || fall !== 2'b01 || rise !== 2'b00)
            $display("FAIL latency_fall: q0=%b fall=%b rise=%b want 0/01/00", q[0], fall, rise);
        else pass_cnt++;
        total++;
        if (cnt !== 4'd2 || sticky !== 2'b01) $display("FAIL latency_count: cnt=%0d sticky=%b want 2/01", cnt, sticky);
        else pass_cnt++;
    endtask

    task automatic test_saturation;
        int want;
        step(2'b00, 1, 0, 0, 1);
        for (int i = 1; i <= 14; i++) begin
            step((i % 2) ? 2'b11 : 2'b00, 1, 0, 0, 0);
            want = (i < 3) ? 0 : ((2 * (i - 2) > 15) ? 15 : 2 * (i - 2));
            total++;
            if (cnt !== want[3:0] || sat !== (want == 15))
                $display("FAIL saturation step %0d: cnt=%0d sat=%b want %0d/%b", i, cnt, sat, want, (want == 15));
            else pass_cnt++;
        end
    endtask

    task automatic test_clear_collision;
        logic [1:0] pat [0:6];
        pat = '{2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 2'b10, 2'b10};
        step(2'b00, 1, 0, 0, 1);
        foreach (pat[i]) step(pat[i], 1, 0, 0, 0);
        total++;
        if (cnt !== 4'd5 || sticky !== 2'b10) $display("FAIL clear_setup: cnt=%0d sticky=%b want 5/10", cnt, sticky);
        else pass_cnt++;
        step(2'b11, 1, 0, 0, 0);
        step(2'b11, 1, 0, 0, 0);
        step(2'b11, 1, 0, 1, 0);
        total++;
        if (cnt !== 4'd1 || sticky !== 2'b01 || rise !== 2'b01)
            $display("FAIL clear_collision: cnt=%0d sticky=%b rise=%b want 1/01/01", cnt, sticky, rise);
        else pass_cnt++;
    endtask

    task automatic test_hold_en;
        logic [1:0] hpat [0:4];
        hpat = '{2'b11, 2'b01, 2'b11, 2'b11, 2'b11};
        step(2'b00, 1, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(2'b01, 1, 0, 0, 0);
        foreach (hpat[i]) begin
            step(hpat[i], 1, 1, 0, 0);
            total++;
            if (q !== 2'b01 || rise !== 2'b00 || fall !== 2'b00)
                $display("FAIL hold_frozen %0d: q=%b rise=%b fall=%b want 01/00/00", i, q, rise, fall);
            else pass_cnt++;
        end
        step(2'b11, 1, 0, 0, 0);
        total++;
        if (q !== 2'b11 || rise !== 2'b10 || cnt !== 4'd2)
            $display("FAIL hold_release: q=%b rise=%b cnt=%0d want 11/10/2", q, rise, cnt);
        else pass_cnt++;
        step(2'b00, 0, 0, 1, 0);
        step(2'b11, 0, 0, 1, 0);
        step(2'b00, 0, 0, 1, 0);
        total++;
        if (q !== 2'b11 || rise !== 2'b00 || fall !== 2'b00 || cnt !== 4'd2 || sticky !== 2'b11)
            $display("FAIL en_freeze: q=%b r=%b f=%b cnt=%0d st=%b want 11/00/00/2/11", q, rise, fall, cnt, sticky);
        else pass_cnt++;
        step(2'b11, 1, 0, 0, 0);
    endtask

    task automatic test_reset_mid;
        step(2'b00, 1, 0, 0, 1);
        for (int i = 1; i <= 9; i++) step((i % 2) ? 2'b01 : 2'b00, 1, 0, 0, 0);
        step(2'b11, 1, 0, 0, 0);
        step(2'b11, 1, 0, 0, 0);
        total++;
        if (cnt !== 4'd9 || q !== 2'b01) $display("FAIL mid_setup: cnt=%0d q=%b want 9/01", cnt, q);
        else pass_cnt++;
        step(2'b00, 1, 0, 0, 1);
        total++;
        if ({q, qb, rise, fall, sticky, cnt, sat} !== {2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 4'd0, 1'b0})
            $display("FAIL mid_reset: q=%b qb=%b r=%b f=%b st=%b cnt=%0d", q, qb, rise, fall, sticky, cnt);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            step(2'b00, 1, 0, 0, 0);
            total++;
            if (rise !== 2'b00 || cnt !== 4'd0) $display("FAIL mid_no_pending: rise=%b cnt=%0d want 00/0", rise, cnt);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset;
        test_latency;
        test_saturation;
        test_clear_collision;
        test_hold_en;
        test_reset_mid;
        total++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_drain: %0d left", exp_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
